// File: rtl/aram_pkg.sv
// Shared types and constants for the audio RAM (ARAM) arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aram_pkg;

  localparam int ARAM_ADDR_W = 16;
  localparam int ARAM_DATA_W = 8;

  // Saturation ceiling of the 4-bit CPU starvation counter.
  localparam logic [3:0] CPU_WAIT_SAT = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_e;

  typedef enum logic {
    OWNER_DSP = 1'b0,
    OWNER_CPU = 1'b1
  } owner_e;

endpackage

// File: rtl/aram_arb_select.sv
// Winner pick for the ARAM port: DSP has fixed priority unless the CPU has starved.
// Latency: purely combinational.
// Backpressure: none; the caller only consults it while idle.
//
// Ports:
//   dsp_req, cpu_req : request levels
//   cpu_wait         : consecutive DSP grants taken while the CPU was waiting
//   grant            : some requester is asking
//   owner            : which requester wins when grant is high
module aram_arb_select
  import aram_pkg::*;
#(
  parameter int CPU_MAX_WAIT = 2
) (
  input  logic       dsp_req,
  input  logic       cpu_req,
  input  logic [3:0] cpu_wait,
  output logic       grant,
  output owner_e     owner
);

  localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

  logic cpu_turn;

  always_comb begin
    grant    = dsp_req | cpu_req;
    // The CPU wins when it is alone, or when it has waited long enough.
    cpu_turn = cpu_req && (!dsp_req || (cpu_wait >= MAX_WAIT));
    owner    = cpu_turn ? OWNER_CPU : OWNER_DSP;
  end

endmodule

// File: rtl/aram_arbiter.sv
// Shares the single ARAM port between the S-DSP and the SPC700 via req/ack handshakes.
// Latency: req sampled at E0, ack high in the cycle after E(1+READ_LATENCY); one access per 3+READ_LATENCY cycles.
// Backpressure: a requester holds req/we/addr/wdata until its one-cycle ack; the loser simply waits.
//
// Ports:
//   clock, reset                         : clock, async active-high reset
//   dsp_* / cpu_*                        : requester interfaces (req, we, addr, wdata in; ack, rdata out)
//   ram_address/ram_wdata/ram_write_enable: ARAM drive; ram_rdata is READ_LATENCY cycles behind the address
//   busy                                 : an access is in flight
// Optional (ARAM_ARB_STATS_EN): stat_dsp_grants, stat_cpu_grants, stat_cpu_max_wait.
module aram_arbiter
  import aram_pkg::*;
#(
  parameter int ADDR_W       = ARAM_ADDR_W,
  parameter int DATA_W       = ARAM_DATA_W,
  parameter int READ_LATENCY = 1,
  parameter int CPU_MAX_WAIT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dsp_req,
  input  logic              dsp_we,
  input  logic [ADDR_W-1:0] dsp_addr,
  input  logic [DATA_W-1:0] dsp_wdata,
  output logic              dsp_ack,
  output logic [DATA_W-1:0] dsp_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_write_enable,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
`ifdef ARAM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_dsp_grants,
  output logic [15:0]       stat_cpu_grants,
  output logic [3:0]        stat_cpu_max_wait
`endif
);

  localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY - 1);

  state_e     state;
  owner_e     owner;
  logic       lat_we;
  logic [1:0] wait_cnt;
  logic [3:0] cpu_wait;
  logic [3:0] cpu_wait_next;

  logic   sel_grant;
  owner_e sel_owner;

  aram_arb_select #(
    .CPU_MAX_WAIT(CPU_MAX_WAIT)
  ) u_select (
    .dsp_req (dsp_req),
    .cpu_req (cpu_req),
    .cpu_wait(cpu_wait),
    .grant   (sel_grant),
    .owner   (sel_owner)
  );

  // Starvation counter value after this cycle's grant (only used when a grant happens).
  always_comb begin
    cpu_wait_next = cpu_wait;
    if (sel_owner == OWNER_CPU) begin
      cpu_wait_next = 4'd0;
    end else if (cpu_req && (cpu_wait != CPU_WAIT_SAT)) begin
      cpu_wait_next = cpu_wait + 4'd1;
    end
  end

  assign busy = (state != IDLE);

  // ram_address / ram_wdata double as the latched address and write data, so
  // they naturally hold their last value outside an access.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      owner            <= OWNER_DSP;
      lat_we           <= 1'b0;
      wait_cnt         <= 2'd0;
      cpu_wait         <= 4'd0;
      ram_address      <= '0;
      ram_wdata        <= '0;
      ram_write_enable <= 1'b0;
      dsp_ack          <= 1'b0;
      cpu_ack          <= 1'b0;
      dsp_rdata        <= '0;
      cpu_rdata        <= '0;
    end else begin
      dsp_ack <= 1'b0;
      cpu_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_grant) begin
            owner    <= sel_owner;
            cpu_wait <= cpu_wait_next;
            state    <= ISSUE;
            if (sel_owner == OWNER_CPU) begin
              lat_we           <= cpu_we;
              ram_address      <= cpu_addr;
              ram_wdata        <= cpu_wdata;
              ram_write_enable <= cpu_we;
            end else begin
              lat_we           <= dsp_we;
              ram_address      <= dsp_addr;
              ram_wdata        <= dsp_wdata;
              ram_write_enable <= dsp_we;
            end
          end
        end
        ISSUE: begin
          ram_write_enable <= 1'b0;
          wait_cnt         <= 2'd0;
          state            <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= ACK;
            if (owner == OWNER_CPU) begin
              cpu_ack <= 1'b1;
              if (!lat_we) cpu_rdata <= ram_rdata;
            end else begin
              dsp_ack <= 1'b1;
              if (!lat_we) dsp_rdata <= ram_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ARAM_ARB_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_dsp_grants   <= 16'd0;
      stat_cpu_grants   <= 16'd0;
      stat_cpu_max_wait <= 4'd0;
    end else if ((state == IDLE) && sel_grant) begin
      if (sel_owner == OWNER_CPU) stat_cpu_grants <= stat_cpu_grants + 16'd1;
      else                        stat_dsp_grants <= stat_dsp_grants + 16'd1;
      if (cpu_wait_next > stat_cpu_max_wait) stat_cpu_max_wait <= cpu_wait_next;
    end
  end
`endif

endmodule

// File: tb/tb_aram_arbiter.sv
// Directed bench for aram_arbiter: one instance at READ_LATENCY=1, one at READ_LATENCY=3,
// each backed by a small RAM model with matching read latency.
module tb_aram_arbiter;

  logic        clock;
  logic        reset;

  // READ_LATENCY = 1 instance
  logic        dsp_req, dsp_we, cpu_req, cpu_we;
  logic [15:0] dsp_addr, cpu_addr;
  logic [7:0]  dsp_wdata, cpu_wdata;
  logic        dsp_ack, cpu_ack, busy;
  logic [7:0]  dsp_rdata, cpu_rdata;
  logic [15:0] ram_address;
  logic [7:0]  ram_wdata, ram_rdata;
  logic        ram_write_enable;

  // READ_LATENCY = 3 instance
  logic        r3_dsp_req, r3_cpu_req;
  logic [15:0] r3_dsp_addr, r3_cpu_addr;
  logic [7:0]  r3_wdata;
  logic        r3_dsp_ack, r3_cpu_ack, r3_busy;
  logic [7:0]  r3_dsp_rdata, r3_cpu_rdata;
  logic [15:0] r3_ram_address;
  logic [7:0]  r3_ram_wdata, r3_ram_rdata;
  logic        r3_ram_write_enable;

`ifdef ARAM_ARB_STATS_EN
  logic [15:0] s_dg, s_cg, r3_s_dg, r3_s_cg;
  logic [3:0]  s_mw, r3_s_mw;
`endif

  aram_arbiter #(.READ_LATENCY(1), .CPU_MAX_WAIT(2)) u_dut (
    .clock(clock), .reset(reset),
    .dsp_req(dsp_req), .dsp_we(dsp_we), .dsp_addr(dsp_addr), .dsp_wdata(dsp_wdata),
    .dsp_ack(dsp_ack), .dsp_rdata(dsp_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ram_address(ram_address), .ram_wdata(ram_wdata),
    .ram_write_enable(ram_write_enable), .ram_rdata(ram_rdata),
    .busy(busy)
`ifdef ARAM_ARB_STATS_EN
    , .stat_dsp_grants(s_dg), .stat_cpu_grants(s_cg), .stat_cpu_max_wait(s_mw)
`endif
  );

  aram_arbiter #(.READ_LATENCY(3), .CPU_MAX_WAIT(2)) u_dut3 (
    .clock(clock), .reset(reset),
    .dsp_req(r3_dsp_req), .dsp_we(1'b0), .dsp_addr(r3_dsp_addr), .dsp_wdata(r3_wdata),
    .dsp_ack(r3_dsp_ack), .dsp_rdata(r3_dsp_rdata),
    .cpu_req(r3_cpu_req), .cpu_we(1'b0), .cpu_addr(r3_cpu_addr), .cpu_wdata(r3_wdata),
    .cpu_ack(r3_cpu_ack), .cpu_rdata(r3_cpu_rdata),
    .ram_address(r3_ram_address), .ram_wdata(r3_ram_wdata),
    .ram_write_enable(r3_ram_write_enable), .ram_rdata(r3_ram_rdata),
    .busy(r3_busy)
`ifdef ARAM_ARB_STATS_EN
    , .stat_dsp_grants(r3_s_dg), .stat_cpu_grants(r3_s_cg), .stat_cpu_max_wait(r3_s_mw)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM models; preload goes through the same process that services writes.
  logic [7:0]  mem1 [65536];
  logic [7:0]  mem3 [65536];
  logic        pre_we, pre_sel;
  logic [15:0] pre_addr;
  logic [7:0]  pre_dat;
  logic [7:0]  p1;
  logic [7:0]  q3 [3];

  always @(posedge clock) begin
    if (pre_we && !pre_sel)    mem1[pre_addr] <= pre_dat;
    else if (ram_write_enable) mem1[ram_address] <= ram_wdata;
    p1 <= mem1[ram_address];
  end
  assign ram_rdata = p1;

  always @(posedge clock) begin
    if (pre_we && pre_sel)        mem3[pre_addr] <= pre_dat;
    else if (r3_ram_write_enable) mem3[r3_ram_address] <= r3_ram_wdata;
    q3[0] <= mem3[r3_ram_address];
    q3[1] <= q3[0];
    q3[2] <= q3[1];
  end
  assign r3_ram_rdata = q3[2];

  int n_total = 0;
  int n_pass  = 0;

  int exp_own [6] = '{0, 0, 1, 0, 0, 1};
  int exp_wt  [6] = '{1, 2, 0, 1, 2, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step;
    @(negedge clock);
  endtask

  task automatic preload(input logic sel, input logic [15:0] a, input logic [7:0] d);
    pre_sel  = sel;
    pre_addr = a;
    pre_dat  = d;
    pre_we   = 1'b1;
    step();
    pre_we   = 1'b0;
  endtask

  initial begin
    int kd, kc, n, we_cnt, ack_cnt;
    reset = 1'b1;
    pre_we = 1'b0; pre_sel = 1'b0; pre_addr = '0; pre_dat = '0;
    dsp_req = 1'b0; dsp_we = 1'b0; dsp_addr = '0; dsp_wdata = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    r3_dsp_req = 1'b0; r3_cpu_req = 1'b0; r3_dsp_addr = '0; r3_cpu_addr = '0; r3_wdata = '0;

    // Reset state
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ram_we", ram_write_enable, 0);
    chk("rst_ram_addr", ram_address, 0);
    chk("rst_acks", {dsp_ack, cpu_ack}, 0);
    chk("rst_rdata", {dsp_rdata, cpu_rdata}, 0);
    chk("rst_cpu_wait", u_dut.cpu_wait, 0);

    preload(1'b0, 16'h1234, 8'h5A);
    preload(1'b0, 16'h0100, 8'h11);
    preload(1'b0, 16'h0200, 8'h77);
    preload(1'b1, 16'h4321, 8'hA7);
    reset = 1'b0;
    step();

    // Simultaneous first request: DSP first, CPU ack 4 cycles later
    dsp_addr = 16'h0100; cpu_addr = 16'h0200;
    dsp_req = 1'b1; cpu_req = 1'b1;
    kd = 0; kc = 0;
    for (int k = 1; k <= 20 && kc == 0; k++) begin
      step();
      if (cpu_ack && kd == 0) chk("sim_cpu_before_dsp", 1, 0);
      if (dsp_ack && kd == 0) begin
        kd = k;
        chk("sim_dsp_rdata", dsp_rdata, 8'h11);
        dsp_req = 1'b0;
      end
      if (cpu_ack) begin
        kc = k;
        chk("sim_cpu_rdata", cpu_rdata, 8'h77);
        cpu_req = 1'b0;
      end
    end
    chk("sim_dsp_ack_cycle", kd, 3);
    chk("sim_cpu_ack_gap", kc - kd, 4);
    step();

    // DSP read of 0x1234
    dsp_addr = 16'h1234; dsp_we = 1'b0; dsp_req = 1'b1;
    step();
    chk("rd_addr_issue", ram_address, 16'h1234);
    chk("rd_busy_issue", busy, 1);
    chk("rd_ack_k1", dsp_ack, 0);
    step();
    chk("rd_ack_k2", dsp_ack, 0);
    step();
    chk("rd_ack_k3", dsp_ack, 1);
    chk("rd_rdata", dsp_rdata, 8'h5A);
    chk("rd_cpu_ack", cpu_ack, 0);
    dsp_req = 1'b0;
    step();
    chk("rd_busy_after", busy, 0);
    chk("rd_ack_after", dsp_ack, 0);
    step();

    // CPU write 0xC3 to 0x00F0
    cpu_addr = 16'h00F0; cpu_wdata = 8'hC3; cpu_we = 1'b1; cpu_req = 1'b1;
    we_cnt = 0; ack_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (ram_write_enable) begin
        we_cnt++;
        chk("wr_addr", ram_address, 16'h00F0);
        chk("wr_data", ram_wdata, 8'hC3);
      end
      if (cpu_ack) begin
        ack_cnt++;
        cpu_req = 1'b0;
      end
    end
    chk("wr_we_cycles", we_cnt, 1);
    chk("wr_ack_pulses", ack_cnt, 1);
    chk("wr_cpu_rdata_kept", cpu_rdata, 8'h77);
    chk("wr_dsp_rdata_kept", dsp_rdata, 8'h5A);
    chk("wr_mem", mem1[16'h00F0], 8'hC3);
    cpu_we = 1'b0;

    // Contention: both held; DSP, DSP, CPU, DSP, DSP, CPU
    dsp_addr = 16'h0100; cpu_addr = 16'h0200;
    dsp_req = 1'b1; cpu_req = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      step();
      if (dsp_ack || cpu_ack) begin
        chk($sformatf("cont_owner%0d", n), cpu_ack, exp_own[n]);
        chk($sformatf("cont_wait%0d", n), u_dut.cpu_wait, exp_wt[n]);
        n++;
      end
    end
    dsp_req = 1'b0; cpu_req = 1'b0;
    chk("cont_grants", n, 6);
    step();
    step();

    // Reset in WAIT of a CPU write
    cpu_addr = 16'h0033; cpu_wdata = 8'h99; cpu_we = 1'b1; cpu_req = 1'b1;
    step();
    chk("rstw_we_issue", ram_write_enable, 1);
    step();
    chk("rstw_busy_wait", busy, 1);
    reset = 1'b1;
    cpu_req = 1'b0;
    #1;
    chk("rstw_we", ram_write_enable, 0);
    chk("rstw_ack", cpu_ack, 0);
    chk("rstw_busy", busy, 0);
    step();
    reset = 1'b0;
    ack_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (cpu_ack || dsp_ack || busy) ack_cnt++;
    end
    chk("rstw_quiet", ack_cnt, 0);
    chk("rstw_cpu_wait", u_dut.cpu_wait, 0);

    // READ_LATENCY=3: ack in the 5th cycle after the sampling edge
    r3_dsp_addr = 16'h4321; r3_dsp_req = 1'b1;
    kd = 0;
    for (int k = 1; k <= 12 && kd == 0; k++) begin
      step();
      if (r3_dsp_ack) begin
        kd = k;
        chk("rl3_rdata", r3_dsp_rdata, 8'hA7);
        r3_dsp_req = 1'b0;
      end
    end
    chk("rl3_ack_cycle", kd, 5);
    step();
    chk("rl3_ack_single", r3_dsp_ack, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
